// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op-code constants, RV32I opcode/funct7 constants and the
// decoded-bundle struct carried from the decoder to the ALU/register file.
// Ports: none (package).
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        illegal;
  } dec_t;

  // funct3 -> ALU op; alt selects sub (000) or sra (101), ignored elsewhere.
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// alu_dec_skid: 2-entry skid buffer (main register drives the outputs, skid
// register catches the word accepted while the output is stalled).
// Ports: clk_i, rst_i, vld_i/dat_i/rdy_o upstream, vld_o/dat_o/rdy_i downstream.
module alu_dec_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         rdy_o,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  input  logic         rdy_i
);

  logic         main_vld_q, main_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q;
  logic         in_fire, out_fire;

  assign in_fire  = vld_i & rdy_q;
  assign out_fire = main_vld_q & rdy_i;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (!main_vld_q || out_fire) begin
      // Main slot frees up: the skid entry is older, so it goes first.
      // rdy_q is low whenever skid is full, so no new word competes with it.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = dat_i;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_d     = dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign rdy_o = rdy_q;
  assign vld_o = main_vld_q;
  assign dat_o = main_q;

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: registered RV32I OP/OP-IMM/LUI decode to ALU op, operand
// selects, immediate and register indices, behind a 2-entry skid buffer.
// Ports: clk_i, rst_i, instr_i/valid_i/ready_o in; bundle + valid_o/ready_i out.
// Option: ALU_DEC_ILLEGAL_CNT_EN adds illegal_cnt_o (saturating count of
// illegal bundles transferred out).
module alu_decoder
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  alu_op_o,
  output logic        use_imm_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        reg_wr_o,
  output logic        illegal_o
`ifdef ALU_DEC_ILLEGAL_CNT_EN
  ,
  output logic [15:0] illegal_cnt_o
`endif
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       is_shift;
  logic       legal;
  dec_t       dec;
  dec_t       bundle;

  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign f7       = instr_i[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opc)
      OPC_OP: begin
        legal      = (f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.alu_op = f3_to_op(f3, f7 == F7_ALT);
        dec.rs1    = instr_i[19:15];
        dec.rs2    = instr_i[24:20];
      end
      OPC_OP_IMM: begin
        // Only shifts constrain imm[11:5]; there it selects srl vs sra.
        legal       = !is_shift || (f7 == F7_BASE) ||
                      ((f3 == 3'b101) && (f7 == F7_ALT));
        dec.alu_op  = f3_to_op(f3, is_shift && (f7 == F7_ALT));
        dec.use_imm = 1'b1;
        dec.imm     = is_shift ? {27'b0, instr_i[24:20]}
                               : {{20{instr_i[31]}}, instr_i[31:20]};
        dec.rs1     = instr_i[19:15];
      end
      OPC_LUI: begin
        legal       = 1'b1;
        dec.alu_op  = ALU_ADD;
        dec.use_imm = 1'b1;
        dec.imm     = {instr_i[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec.rd     = instr_i[11:7];
      dec.reg_wr = (instr_i[11:7] != 5'd0);
    end else begin
      dec         = '0;
      dec.alu_op  = ALU_ILL;
      dec.illegal = 1'b1;
    end
  end

  alu_dec_skid #(.W($bits(dec_t))) u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (valid_i),
    .dat_i (dec),
    .rdy_o (ready_o),
    .vld_o (valid_o),
    .dat_o (bundle),
    .rdy_i (ready_i)
  );

  assign alu_op_o  = bundle.alu_op;
  assign use_imm_o = bundle.use_imm;
  assign imm_o     = bundle.imm;
  assign rs1_o     = bundle.rs1;
  assign rs2_o     = bundle.rs2;
  assign rd_o      = bundle.rd;
  assign reg_wr_o  = bundle.reg_wr;
  assign illegal_o = bundle.illegal;

`ifdef ALU_DEC_ILLEGAL_CNT_EN
  logic [15:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (valid_o && ready_i && bundle.illegal && (ill_cnt_q != 16'hFFFF))
      ill_cnt_d = ill_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ill_cnt_q <= '0;
    else       ill_cnt_q <= ill_cnt_d;
  end

  assign illegal_cnt_o = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: self-checking bench for alu_decoder with a queue-based
// reference model of decode and buffering.
// Ports: none (top-level bench).
module tb_alu_decoder;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, valid_o;
  logic        ready_i = 1'b0;
  logic [3:0]  alu_op_o;
  logic        use_imm_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        reg_wr_o, illegal_o;
`ifdef ALU_DEC_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_o;
`endif

  int total = 0;
  int bad   = 0;
  dec_t q[$];
  int   accepted = 0;
  int   emitted  = 0;
  int   cnt_m    = 0;

  always #5 clk_i = ~clk_i;

  alu_decoder dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .instr_i   (instr_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .alu_op_o  (alu_op_o),
    .use_imm_o (use_imm_o),
    .imm_o     (imm_o),
    .rs1_o     (rs1_o),
    .rs2_o     (rs2_o),
    .rd_o      (rd_o),
    .reg_wr_o  (reg_wr_o),
    .illegal_o (illegal_o)
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    ,
    .illegal_cnt_o (illegal_cnt_o)
`endif
  );

  // Reference decode written from the instruction-set rules with integers.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    int opc, f3, f7, op;
    bit ok;
    int base_op [8];
    base_op = '{0, 2, 3, 4, 5, 6, 8, 9};
    opc = int'(ins[6:0]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    d   = '0;
    ok  = 0;
    op  = 0;
    if (opc == 'h33) begin
      ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
      op = base_op[f3];
      if (f7 == 'h20) op = op + 1;         // add->sub, srl->sra
      d.rs1 = ins[19:15];
      d.rs2 = ins[24:20];
    end else if (opc == 'h13) begin
      if (f3 == 1)      ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0) || (f7 == 'h20);
      else              ok = 1;
      op = base_op[f3];
      if (f3 == 5 && f7 == 'h20) op = op + 1;
      d.use_imm = 1;
      if (f3 == 1 || f3 == 5) d.imm = 32'(ins[24:20]);
      else                    d.imm = 32'($signed(ins[31:20]));
      d.rs1 = ins[19:15];
    end else if (opc == 'h37) begin
      ok = 1;
      op = 0;
      d.use_imm = 1;
      d.imm = ins & 32'hFFFF_F000;
    end
    if (ok) begin
      d.alu_op = 4'(op);
      d.rd     = ins[11:7];
      d.reg_wr = (ins[11:7] != 0);
    end else begin
      d = '0;
      d.alu_op  = 4'hF;
      d.illegal = 1;
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = int'($urandom_range(0, 9));
    if (sel < 4)      r[6:0] = 7'h33;
    else if (sel < 8) r[6:0] = 7'h13;
    else if (sel < 9) r[6:0] = 7'h37;
    sel = int'($urandom_range(0, 3));
    if (sel == 0)      r[31:25] = 7'h00;
    else if (sel == 1) r[31:25] = 7'h20;
    return r;
  endfunction

  // Advances one clock and updates the scoreboard from the handshakes seen.
  task automatic tick();
    bit inf, outf;
    inf  = valid_i && ready_o;
    outf = valid_o && ready_i;
    if (outf && q.size() > 0) begin
      if (q[0].illegal && cnt_m != 'hFFFF) cnt_m++;
      void'(q.pop_front());
      emitted++;
    end
    if (inf) begin
      q.push_back(ref_decode(instr_i));
      accepted++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_low got=%b want=0", ready_o); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    total++;
    if ({alu_op_o, use_imm_o, imm_o, rs1_o, rs2_o, rd_o, reg_wr_o, illegal_o} !== '0) begin
      bad++; $display("FAIL reset_bundle got op=%h imm=%h ill=%b want all zero", alu_op_o, imm_o, illegal_o);
    end
    rst_i = 1'b0;
    q.delete(); cnt_m = 0;
    @(posedge clk_i); #1;
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_release got=%b want=1", ready_o); end
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    total++;
    if (illegal_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", illegal_cnt_o); end
`endif
  endtask

  task automatic test_directed();
    logic [31:0] ins  [7] = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'hFFF00093,
                              32'h123453B7, 32'h00000000, 32'h4020C1B3};
    logic [3:0]  e_op [7] = '{4'h0, 4'h1, 4'h7, 4'h0, 4'h0, 4'hF, 4'hF};
    logic [31:0] e_imm[7] = '{32'h0, 32'h0, 32'h3, 32'hFFFFFFFF, 32'h12345000, 32'h0, 32'h0};
    logic [4:0]  e_rs1[7] = '{5'd1, 5'd1, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0]  e_rd [7] = '{5'd3, 5'd3, 5'd5, 5'd1, 5'd7, 5'd0, 5'd0};
    logic [2:0]  e_flg[7] = '{3'b010, 3'b010, 3'b110, 3'b110, 3'b110, 3'b001, 3'b001}; // use_imm,reg_wr,illegal
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [15:0] cnt0;
    cnt0 = illegal_cnt_o;
`endif
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      valid_i = 1'b1; instr_i = ins[i];
      tick();
      valid_i = 1'b0;
      total++;
      if (valid_o !== 1'b1 || alu_op_o !== e_op[i] || imm_o !== e_imm[i]) begin
        bad++; $display("FAIL dir%0d_op_imm got v=%b op=%h imm=%h want v=1 op=%h imm=%h",
                        i, valid_o, alu_op_o, imm_o, e_op[i], e_imm[i]);
      end
      total++;
      if (rs1_o !== e_rs1[i] || rd_o !== e_rd[i] || {use_imm_o, reg_wr_o, illegal_o} !== e_flg[i]) begin
        bad++; $display("FAIL dir%0d_fields got rs1=%0d rd=%0d flg=%b want rs1=%0d rd=%0d flg=%b",
                        i, rs1_o, rd_o, {use_imm_o, reg_wr_o, illegal_o}, e_rs1[i], e_rd[i], e_flg[i]);
      end
      if (i == 0) begin
        total++;
        if (rs2_o !== 5'd2) begin bad++; $display("FAIL dir_add_rs2 got=%0d want=2", rs2_o); end
      end
      tick();
    end
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    total++;
    if (illegal_cnt_o !== cnt0 + 16'd2) begin
      bad++; $display("FAIL dir_cnt got=%0d want=%0d", illegal_cnt_o, cnt0 + 16'd2);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [4] = '{32'h00208233, 32'h402082B3, 32'h00500313, 32'h000013B7}; // rd 4,5,6,7
    int nxt = 0;
    int base = emitted;
    int got_rd [$];
    ready_i = 1'b0;
    for (int c = 0; c < 40 && (emitted - base) < 4; c++) begin
      if (c == 3) ready_i = 1'b1;
      valid_i = (nxt < 4);
      instr_i = (nxt < 4) ? ins[nxt] : 32'h0;
      if (c == 2) begin
        total++;
        if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", ready_o); end
      end
      if (valid_o && ready_i) got_rd.push_back(int'(rd_o));
      if (valid_i && ready_o) nxt++;
      tick();
    end
    valid_i = 1'b0;
    total++;
    if (got_rd.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d want=4", got_rd.size());
    end else begin
      total++;
      if (got_rd[0] != 4 || got_rd[1] != 5 || got_rd[2] != 6 || got_rd[3] != 7) begin
        bad++; $display("FAIL bp_order got=%0d,%0d,%0d,%0d want=4,5,6,7",
                        got_rd[0], got_rd[1], got_rd[2], got_rd[3]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      instr_i = rand_instr();
      ready_i = ($urandom_range(0, 2) != 0);
      total++;
      if (valid_o !== (q.size() > 0) || ready_o !== (q.size() < 2)) begin
        bad++; $display("FAIL rnd_occ cyc=%0d got v=%b r=%b want held=%0d", c, valid_o, ready_o, q.size());
      end
      if (q.size() > 0) begin
        total++;
        if ({alu_op_o, use_imm_o, imm_o, rs1_o, rs2_o, rd_o, reg_wr_o, illegal_o} !== q[0]) begin
          bad++; $display("FAIL rnd_bundle cyc=%0d got=%h want=%h", c,
                          {alu_op_o, use_imm_o, imm_o, rs1_o, rs2_o, rd_o, reg_wr_o, illegal_o}, q[0]);
        end
      end
`ifdef ALU_DEC_ILLEGAL_CNT_EN
      total++;
      if (illegal_cnt_o !== 16'(cnt_m)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", c, illegal_cnt_o, cnt_m);
      end
`endif
      tick();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    valid_i = 1'b1; instr_i = 32'h00100093; tick();
    instr_i = 32'h00200113; tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      bad++; $display("FAIL rmid_full got v=%b r=%b want v=1 r=0", valid_o, ready_o);
    end
    rst_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    q.delete(); cnt_m = 0;
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", valid_o); end
    @(posedge clk_i); #1;
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++; $display("FAIL rmid_after got r=%b v=%b want r=1 v=0", ready_o, valid_o);
    end
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    total++;
    if (illegal_cnt_o !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", illegal_cnt_o); end
`endif
    // A fresh instruction must be the next thing out, not a stale entry.
    valid_i = 1'b1; instr_i = 32'h00A00513; tick();
    valid_i = 1'b0;
    total++;
    if (valid_o !== 1'b1 || rd_o !== 5'd10 || imm_o !== 32'd10) begin
      bad++; $display("FAIL rmid_fresh got v=%b rd=%0d imm=%0d want v=1 rd=10 imm=10", valid_o, rd_o, imm_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
# alu_decoder

Registered instruction-to-ALU decode stage for the RV32I core. Accepts 32-bit instruction words over a valid/ready handshake and emits the 4-bit ALU operation code, operand selects, immediate and register indices one cycle later. Covers the integer computational subset: OP, OP-IMM and LUI. It sits between instruction fetch and the `alu` / register file, and produces exactly the op encoding the `alu` consumes.

## Interface
- No parameters; all widths are fixed by RV32I.
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; one clock; reset is synchronous and active-high
- instr_i  input  32  instruction word
- valid_i  input  1  instr_i valid
- ready_o  output  1  decoder can accept; registered
- valid_o  output  1  decoded bundle valid
- ready_i  input  1  downstream accepts the bundle
- alu_op_o  output  4  ALU op code: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and, 1111 illegal/nop
- use_imm_o  output  1  operand b comes from imm_o, not rs2
- imm_o  output  32  immediate
- rs1_o, rs2_o, rd_o  output  5 each  register indices
- reg_wr_o  output  1  write rd
- illegal_o  output  1  instruction not decodable

## Operation
- Transfers: input on valid_i & ready_o; output on valid_o & ready_i.
- Decode by opcode instr[6:0]:
  - OP (0110011), by funct3:
    - 000: add (funct7 0000000) or sub (funct7 0100000)
    - 001: sll; 010: slt; 011: sltu; 100: xor
    - 101: srl (funct7 0000000) or sra (funct7 0100000)
    - 110: or; 111: and
    - funct7 0100000 with any other funct3 is illegal; any other funct7 is illegal.
    - use_imm_o=0; imm_o=0.
  - OP-IMM (0010011): same funct3 map, with no sub.
    - imm_o = sign-extended instr[31:20].
    - Shifts (001, 101): imm_o = {27'b0, instr[24:20]}.
    - slli/srli require instr[31:25]=0000000; srai requires 0100000; any other value is illegal.
    - use_imm_o=1; rs2_o=0.
  - LUI (0110111): op add; rs1_o=0; use_imm_o=1; imm_o = {instr[31:12], 12'b0}.
  - Any other opcode is illegal.
- Illegal instructions: illegal_o=1, alu_op_o=1111, reg_wr_o=0, use_imm_o=0, indices and imm=0. Still presented through the handshake; never dropped.
- reg_wr_o = legal & (rd != 0).
- Buffering: 2-entry skid buffer (main plus skid register).
  - ready_o = skid entry empty.
  - Order preserved; no loss or duplication under any ready_i pattern.

## Timing
- Latency: bundle visible on valid_o the cycle after input acceptance.
- Throughput: one instruction per cycle while ready_i=1.
- ready_o deasserts the cycle after a second entry is held while ready_i=0, and reasserts the cycle after that entry drains.
- valid_o and all bundle fields are stable while valid_o=1 & ready_i=0.
- Simultaneous accept and drain with one entry held: occupancy stays at 1 and the new bundle replaces the old.
- Reset values: valid_o=0; all bundle outputs 0 (alu_op_o=0000).
  - ready_o=1 from the first cycle after rst_i deasserts; ready_o=0 while rst_i=1.
  - Reset mid-operation discards all held entries.

## Configuration
- ALU_DEC_ILLEGAL_CNT_EN defined:
  - Adds output illegal_cnt_o [15:0], a counter of illegal instructions transferred out.
  - Saturates at 0xFFFF; reset value 0.
- ALU_DEC_ILLEGAL_CNT_EN not defined: no port and no counter logic.

## Structure
- Package alu_pkg holds:
  - the 4-bit op-code constants (shared with `alu`);
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI;
  - funct7 constants F7_BASE, F7_ALT;
  - a decoded-bundle packed struct.
- Decode is combinational on instr_i; the bundle is stored in the buffer.
- Sub-module alu_dec_skid: generic 2-entry skid buffer carrying the bundle struct.

## Test plan
- ADD x3,x1,x2 (0x002081B3) -> next cycle: valid_o=1, alu_op_o=0000, rs1_o=1, rs2_o=2, rd_o=3, use_imm_o=0, reg_wr_o=1.
- SUB (0x402081B3) -> alu_op_o=0001. SRAI x5,x6,3 (0x40335293) -> alu_op_o=0111, imm_o=3, rs1_o=6, rd_o=5, use_imm_o=1.
- ADDI x1,x0,-1 (0xFFF00093) -> imm_o=0xFFFFFFFF, alu_op_o=0000. LUI x7,0x12345 (0x123453B7) -> imm_o=0x12345000, rs1_o=0.
- Input 0x00000000 and 0x0020D1B3 (funct7 0 is fine; make it 0x4020C1B3, xor with alt funct7) -> illegal_o=1, alu_op_o=1111, reg_wr_o=0; illegal_cnt_o increments by 2 when the macro is defined.
- ready_i=0 for 3 cycles with valid_i=1 streaming 4 instructions -> ready_o=0 after 2 are held; all 4 emerge in order once ready_i=1.
- rst_i=1 for one cycle with 2 entries held -> valid_o=0 the next cycle, ready_o=1, held entries never emitted.
